// File: rtl/mmio_pkg.sv
// Shared types and defaults for the MMIO register-port arbiter.
// Optional build macro used by the arbiter: MMIO_ARB_TIMEOUT_EN.
package mmio_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int MMIO_DW = 16;
    localparam int MMIO_AW = 2;

    // Successor of a master index, wrapping back to master 0 after the last one.
    function automatic int wrap_inc(input int idx, input int n);
        if (idx + 1 >= n) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/mmio_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping, reported both one-hot and as an index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    // Scan the requests in priority order starting at the pointer.
    always_comb begin
        int  k;
        logic hit_s;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        k       = 0;
        hit_s   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            k       = (int'(ptr) + i) % NREQ;
            hit_s   = !any && req[k];
            win[k]  = hit_s;
            win_idx = hit_s ? IW'(k) : win_idx;
            any     = any | hit_s;
        end
    end

endmodule

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO slave register port between NREQ masters.
// Define MMIO_ARB_TIMEOUT_EN to abort accesses whose slave never answers.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = MMIO_AW,
    parameter int DW      = MMIO_DW,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   m_sel,
    input  logic [NREQ-1:0]   m_we,
    input  logic [NREQ-1:0]   m_re,
    input  logic [NREQ*AW-1:0] m_addr,
    input  logic [NREQ*DW-1:0] m_wdata,
    output logic [DW-1:0]     m_rdata,
    output logic [NREQ-1:0]   m_rdy,
    output logic [NREQ-1:0]   m_err,
    output logic [NREQ-1:0]   gnt,
    output logic              s_sel,
    output logic              s_we,
    output logic              s_re,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    input  logic [DW-1:0]     s_rdata,
    input  logic              s_rdy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Unsupported sizes elaborate this marker so they are easy to spot in the hierarchy.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_cfg_out_of_range
    end

    arb_state_t      state_r, state_nxt_s;
    logic [NREQ-1:0] gnt_r, gnt_nxt_s;
    logic [IW-1:0]   gidx_r, gidx_nxt_s;
    logic [IW-1:0]   ptr_r, ptr_nxt_s;

    logic [NREQ-1:0] pick_win_s;
    logic [IW-1:0]   pick_idx_s;
    logic            pick_any_s;

    logic granted_s;
    logic g_sel_s;
    logic done_ok_s;
    logic abort_s;
    logic timeout_s;
    logic finish_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req     (m_sel),
        .ptr     (ptr_r),
        .win     (pick_win_s),
        .win_idx (pick_idx_s),
        .any     (pick_any_s)
    );

    assign granted_s = (state_r == ARB_GRANT);
    assign g_sel_s   = m_sel[gidx_r];
    assign done_ok_s = granted_s & g_sel_s & s_rdy;
    // A master withdrawing its request while granted ends the access silently.
    assign abort_s   = granted_s & ~g_sel_s;
    assign finish_s  = done_ok_s | abort_s | timeout_s;

`ifdef MMIO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_r;

    assign timeout_s = granted_s & g_sel_s & ~s_rdy & (cnt_r == CW'(TIMEOUT));

    // Count granted cycles still waiting on the slave; cleared whenever not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (granted_s && !finish_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbitration state, current grant and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
            gnt_r   <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            gidx_r  <= gidx_nxt_s;
            ptr_r   <= ptr_nxt_s;
        end
    end

    // Next-state logic: one IDLE bubble between grants, grant held until the access ends.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        gidx_nxt_s  = gidx_r;
        ptr_nxt_s   = ptr_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = ARB_GRANT;
                    gnt_nxt_s   = pick_win_s;
                    gidx_nxt_s  = pick_idx_s;
                end else begin
                    gnt_nxt_s   = '0;
                end
            end
            ARB_GRANT: begin
                if (finish_s) begin
                    state_nxt_s = ARB_IDLE;
                    gnt_nxt_s   = '0;
                    ptr_nxt_s   = IW'(wrap_inc(int'(gidx_r), NREQ));
                end else begin
                    gnt_nxt_s   = gnt_r;
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
                gnt_nxt_s   = '0;
            end
        endcase
    end

    // Slave-side mux of the granted master; quiet when nobody holds the grant.
    always_comb begin
        s_sel   = 1'b0;
        s_we    = 1'b0;
        s_re    = 1'b0;
        s_addr  = '0;
        s_wdata = '0;
        if (granted_s) begin
            s_sel   = m_sel[gidx_r];
            s_we    = m_we[gidx_r];
            s_re    = m_re[gidx_r];
            s_addr  = m_addr[int'(gidx_r)*AW +: AW];
            s_wdata = m_wdata[int'(gidx_r)*DW +: DW];
        end else begin
            s_sel   = 1'b0;
        end
    end

    // Completion is returned to the winner only; timed-out accesses return zero data.
    always_comb begin
        m_rdy   = '0;
        m_err   = '0;
        m_rdata = '0;
        if (done_ok_s) begin
            m_rdy   = gnt_r;
            m_rdata = s_rdata;
        end else if (timeout_s) begin
            m_rdy   = gnt_r;
            m_err   = gnt_r;
        end else begin
            m_rdata = '0;
        end
    end

    assign gnt = gnt_r;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter (NREQ=2): vector table, corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_mmio_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 2;
    localparam int DW   = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   m_sel, m_we, m_re;
    logic [NREQ*AW-1:0] m_addr;
    logic [NREQ*DW-1:0] m_wdata;
    logic [DW-1:0]     m_rdata;
    logic [NREQ-1:0]   m_rdy, m_err, gnt;
    logic              s_sel, s_we, s_re;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [DW-1:0]     s_rdata;
    logic              s_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (15)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_sel   (m_sel),
        .m_we    (m_we),
        .m_re    (m_re),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_rdy   (m_rdy),
        .m_err   (m_err),
        .gnt     (gnt),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_re    (s_re),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_rdy   (s_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [1:0]  we;
        logic [1:0]  re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        srdy;
        logic [15:0] srdata;
        logic [42:0] exp;
    } vec_t;

    vec_t vec_q[$];

    function automatic logic [42:0] pack_dut();
        return {gnt, s_sel, s_we, s_re, s_addr, s_wdata, m_rdy, m_err, m_rdata};
    endfunction

    function automatic logic [42:0] expv(input logic [1:0] g, input logic ss, input logic sw,
                                         input logic sr, input logic [1:0] sa, input logic [15:0] sd,
                                         input logic [1:0] rdy, input logic [15:0] rd);
        return {g, ss, sw, sr, sa, sd, rdy, 2'b00, rd};
    endfunction

    task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] sel, input logic [1:0] we, input logic [1:0] re,
                         input logic [3:0] addr, input logic [31:0] wdata,
                         input logic srdy, input logic [15:0] srdata);
        m_sel = sel; m_we = we; m_re = re; m_addr = addr; m_wdata = wdata;
        s_rdy = srdy; s_rdata = srdata;
    endtask

    task automatic add(input logic [1:0] sel, input logic [1:0] we, input logic [1:0] re,
                       input logic [3:0] addr, input logic [31:0] wdata,
                       input logic srdy, input logic [15:0] srdata, input logic [42:0] exp);
        vec_t v;
        v.sel = sel; v.we = we; v.re = re; v.addr = addr; v.wdata = wdata;
        v.srdy = srdy; v.srdata = srdata; v.exp = exp;
        vec_q.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        check("reset_state", pack_dut(), 43'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int owner;
        int last;
        logic [1:0]  eg, er;
        logic        es, ew, erd;
        logic [1:0]  ea;
        logic [15:0] ed, erdata;
        logic [1:0]  prev_rdy;

        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b0, 16'h0);
        #1;
        check("async_reset_outputs", pack_dut(), 43'h0);
        do_reset();

        // Sequence from reset: single write, contention, wait state, abort, we+re together.
        add(2'b01, 2'b01, 2'b00, 4'h0, 32'h0000_000A, 1'b1, 16'h5555, 43'h0);
        add(2'b01, 2'b01, 2'b00, 4'h0, 32'h0000_000A, 1'b1, 16'h5555, expv(2'b01, 1'b1, 1'b1, 1'b0, 2'd0, 16'h000A, 2'b01, 16'h5555));
        add(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b1, 16'h1111, 43'h0);
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'hBEEF, 43'h0);
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'hBEEF, expv(2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 2'b10, 16'hBEEF));
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h2222, 43'h0);
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'hC0DE, expv(2'b01, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 2'b01, 16'hC0DE));
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h3333, 43'h0);
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b0, 16'h4444, expv(2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 2'b00, 16'h0));
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h0F0F, expv(2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 2'b10, 16'h0F0F));
        add(2'b01, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h6666, 43'h0);
        add(2'b00, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h7777, expv(2'b01, 1'b0, 1'b0, 1'b1, 2'd2, 16'h0, 2'b00, 16'h0));
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h8888, 43'h0);
        add(2'b11, 2'b00, 2'b11, 4'b1010, 32'h0, 1'b1, 16'h9999, expv(2'b10, 1'b1, 1'b0, 1'b1, 2'd2, 16'h0, 2'b10, 16'h9999));
        add(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b1, 16'h0, 43'h0);
        add(2'b01, 2'b01, 2'b01, 4'b0011, 32'h0000_FFFF, 1'b1, 16'h0, 43'h0);
        add(2'b01, 2'b01, 2'b01, 4'b0011, 32'h0000_FFFF, 1'b1, 16'h0, expv(2'b01, 1'b1, 1'b1, 1'b1, 2'd3, 16'hFFFF, 2'b01, 16'h0));
        add(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b1, 16'h0, 43'h0);

        foreach (vec_q[i]) begin
            drive(vec_q[i].sel, vec_q[i].we, vec_q[i].re, vec_q[i].addr, vec_q[i].wdata,
                  vec_q[i].srdy, vec_q[i].srdata);
            @(negedge clk);
            check($sformatf("vec%0d", i), pack_dut(), vec_q[i].exp);
            @(posedge clk); #1;
        end

        // Wait-state slave: grant held 4 cycles with stable slave signals, one m_rdy.
        do_reset();
        drive(2'b01, 2'b01, 2'b00, 4'b0001, 32'h0000_1234, 1'b0, 16'hAAAA);
        @(negedge clk);
        check("wait_idle", pack_dut(), 43'h0);
        for (int w = 1; w <= 4; w++) begin
            @(posedge clk); #1;
            s_rdy = (w == 4);
            @(negedge clk);
            check($sformatf("wait_c%0d", w), pack_dut(),
                  expv(2'b01, 1'b1, 1'b1, 1'b0, 2'd1, 16'h1234, (w == 4) ? 2'b01 : 2'b00, (w == 4) ? 16'hAAAA : 16'h0));
        end
        @(posedge clk); #1;
        drive(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b0, 16'h0);
        @(negedge clk);
        check("wait_release", pack_dut(), 43'h0);

        // Async reset while granted drops the access; the pointer restarts at master 0.
        do_reset();
        drive(2'b10, 2'b00, 2'b10, 4'b0100, 32'h0, 1'b0, 16'h1357);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_grant", pack_dut(), expv(2'b10, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0, 2'b00, 16'h0));
        #2;
        rst_n = 1'b0;
        s_rdy = 1'b1;
        #1;
        check("rst_mid_access", pack_dut(), 43'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(2'b11, 2'b00, 2'b11, 4'b0110, 32'h0, 1'b0, 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_next_master0", {41'h0, gnt}, {41'h0, 2'b01});

`ifdef MMIO_ARB_TIMEOUT_EN
        do_reset();
        drive(2'b01, 2'b00, 2'b01, 4'h0, 32'h0, 1'b0, 16'hDEAD);
        cyc = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cyc < 0 && m_rdy != 2'b00) begin
                cyc = c;
                check("timeout_flags", {25'h0, m_rdy, m_err, m_rdata}, {25'h0, 2'b01, 2'b01, 16'h0});
            end
            @(posedge clk); #1;
        end
        check("timeout_cycle", 43'(cyc), 43'd16);
`else
        do_reset();
        drive(2'b01, 2'b00, 2'b01, 4'h0, 32'h0, 1'b0, 16'hDEAD);
        cyc = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m_rdy != 2'b00 || m_err != 2'b00) cyc++;
            @(posedge clk); #1;
        end
        check("no_timeout_default", 43'(cyc), 43'd0);
        check("no_timeout_gnt_held", {41'h0, gnt}, {41'h0, 2'b01});
`endif

        // Randomized traffic against a transaction-level model of round-robin service.
        do_reset();
        drive(2'b00, 2'b00, 2'b00, 4'h0, 32'h0, 1'b0, 16'h0);
        owner    = -1;
        last     = NREQ - 1;
        prev_rdy = 2'b00;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            eg = 2'b00; es = 1'b0; ew = 1'b0; erd = 1'b0; ea = 2'd0; ed = 16'h0;
            er = 2'b00; erdata = 16'h0;
            if (owner >= 0) begin
                eg  = 2'(1 << owner);
                es  = m_sel[owner];
                ew  = m_we[owner];
                erd = m_re[owner];
                ea  = m_addr[owner*AW +: AW];
                ed  = m_wdata[owner*DW +: DW];
                if (m_sel[owner] && s_rdy) begin
                    er     = eg;
                    erdata = s_rdata;
                end
            end
            check($sformatf("rand_c%0d", c), pack_dut(), expv(eg, es, ew, erd, ea, ed, er, erdata));
            if (owner >= 0) begin
                if (!m_sel[owner] || s_rdy) begin
                    last  = owner;
                    owner = -1;
                end
            end else begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (owner < 0 && m_sel[(last + i) % NREQ]) owner = (last + i) % NREQ;
                end
            end
            prev_rdy = er;
            @(posedge clk); #1;
            for (int k = 0; k < NREQ; k++) begin
                if (m_sel[k] && !prev_rdy[k]) begin
                    if ($urandom_range(19, 0) == 0) m_sel[k] = 1'b0;
                end else if ((m_sel[k] && prev_rdy[k]) || $urandom_range(9, 0) < 4) begin
                    m_sel[k] = (m_sel[k] && prev_rdy[k]) ? 1'($urandom_range(1, 0)) : 1'b1;
                    m_we[k]  = 1'($urandom_range(1, 0));
                    m_re[k]  = 1'($urandom_range(1, 0));
                    m_addr[k*AW +: AW]  = AW'($urandom_range(3, 0));
                    m_wdata[k*DW +: DW] = DW'($urandom);
                end else begin
                    m_sel[k] = 1'b0;
                end
            end
            s_rdy   = ($urandom_range(2, 0) != 0);
            s_rdata = DW'($urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
